// File: rtl/seq_alu_display.sv
// seq_alu_display: multi-cycle signed add/sub/mul/div with sequential double-dabble to seven-segment digits.
// Define SEQ_ALU_LZ_BLANK_EN to blank digits above the most significant non-zero digit.
module seq_alu_display #(
   parameter int WIDTH  = 6,
   parameter int DIGITS = 4,
   parameter int N_SEGS = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WIDTH-1:0]       a,
   input  logic [WIDTH-1:0]       b,
   input  logic [2:0]             func,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic [2*WIDTH-1:0]     out,
   output logic [0:7*N_SEGS-1]    segs,
   output logic                   err
);
   localparam int RW = 2 * WIDTH;
   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(RW + 2);
   localparam logic [CW-1:0] C_OPS  = CW'(WIDTH);
   localparam logic [CW-1:0] C_RES  = CW'(RW);
   localparam logic [CW-1:0] C_SHOW = CW'(RW + 1);
   localparam logic [6:0] SEG_BLANK = 7'h7f;
   localparam logic [6:0] SEG_DASH  = 7'h3f;
`ifdef SEQ_ALU_LZ_BLANK_EN
   localparam bit LZ = 1'b1;
`else
   localparam bit LZ = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, CALC, CONV, DONE} state_t;

   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0] fn_q, fn_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, ma_q, ma_d, mb_q, mb_d;
   logic [RW-1:0] acc_q, acc_d, res_q, res_d, mag_q, mag_d, out_q, out_d;
   logic [BW-1:0] bcd_q, bcd_d, dab;
   logic [7:0] bcd_a_q, bcd_a_d;
   logic fault_q, fault_d, err_q, err_d;
   logic [7*N_SEGS-1:0] seg_q, seg_d, seg_c;
   logic [WIDTH-1:0] abs_a, abs_b;
   logic [WIDTH:0] quo_t;
   logic quo_ge, calc_fin;
   logic [RW-1:0] sa, sb, mdv, calc_res;

   // active-low glyph, bit k drives segment k (a..g)
   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0: seg7 = 7'h40;
         4'd1: seg7 = 7'h79;
         4'd2: seg7 = 7'h24;
         4'd3: seg7 = 7'h30;
         4'd4: seg7 = 7'h19;
         4'd5: seg7 = 7'h12;
         4'd6: seg7 = 7'h02;
         4'd7: seg7 = 7'h78;
         4'd8: seg7 = 7'h00;
         4'd9: seg7 = 7'h10;
         default: seg7 = SEG_BLANK;
      endcase
   endfunction

   always_comb begin
      abs_a = a[WIDTH-1] ? -a : a;
      abs_b = b[WIDTH-1] ? -b : b;
      sa = {{WIDTH{a_q[WIDTH-1]}}, a_q};
      sb = {{WIDTH{b_q[WIDTH-1]}}, b_q};
      quo_t = {acc_q[WIDTH-1:0], ma_q[WIDTH-1]};
      quo_ge = quo_t >= {1'b0, mb_q};
      mdv = fn_q[0] ? RW'(ma_q) : acc_q;
      calc_fin = !fn_q[1] || (fn_q[0] && mb_q == '0) || cnt_q == C_OPS;
      calc_res = !fn_q[1] ? (fn_q[0] ? sa - sb : sa + sb)
               : (fn_q[0] && mb_q == '0) ? '0
               : (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -mdv : mdv;
      for (int i = 0; i < DIGITS; i++)
         dab[4*i +: 4] = bcd_q[4*i +: 4] >= 4'd5 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
   end

   always_comb begin
      seg_c = '1;
      if (fn_q[2]) begin
         seg_c[6:0]   = seg7(bcd_q[3:0]);
         seg_c[13:7]  = (LZ && bcd_q[7:4] == 4'd0) ? SEG_BLANK : seg7(bcd_q[7:4]);
         seg_c[20:14] = b_q[WIDTH-1] ? SEG_DASH : SEG_BLANK;
         seg_c[34:28] = seg7(bcd_a_q[3:0]);
         seg_c[41:35] = (LZ && bcd_a_q[7:4] == 4'd0) ? SEG_BLANK : seg7(bcd_a_q[7:4]);
         seg_c[48:42] = a_q[WIDTH-1] ? SEG_DASH : SEG_BLANK;
      end else begin
         for (int i = 0; i < DIGITS; i++)
            seg_c[7*i +: 7] = fault_q ? SEG_DASH
                            : (LZ && i > 0 && (bcd_q >> (4*i)) == '0) ? SEG_BLANK
                            : seg7(bcd_q[4*i +: 4]);
         seg_c[7*DIGITS +: 7] = (fault_q || res_q[RW-1]) ? SEG_DASH : SEG_BLANK;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      fn_d = fn_q;
      a_d = a_q;
      b_d = b_q;
      ma_d = ma_q;
      mb_d = mb_q;
      acc_d = acc_q;
      res_d = res_q;
      mag_d = mag_q;
      bcd_d = bcd_q;
      bcd_a_d = bcd_a_q;
      fault_d = fault_q;
      out_d = out_q;
      err_d = err_q;
      seg_d = seg_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = func[2] ? CONV : CALC;
            cnt_d = '0;
            fn_d = func;
            a_d = a;
            b_d = b;
            ma_d = abs_a;
            mb_d = abs_b;
            acc_d = '0;
            bcd_d = '0;
            fault_d = 1'b0;
            mag_d = {abs_a, abs_b};
         end
         CALC: if (calc_fin) begin
            state_d = CONV;
            cnt_d = '0;
            res_d = calc_res;
            mag_d = calc_res[RW-1] ? -calc_res : calc_res;
            fault_d = fn_q[1] && fn_q[0] && mb_q == '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
            if (fn_q[0]) begin
               acc_d = RW'(quo_ge ? quo_t - {1'b0, mb_q} : quo_t);
               ma_d = {ma_q[WIDTH-2:0], quo_ge};
            end else begin
               acc_d = acc_q + (mb_q[0] ? RW'(ma_q) << cnt_q : '0);
               mb_d = mb_q >> 1;
            end
         end
         // show mode parks |a| digits halfway, then converts |b|
         CONV: if (cnt_q == (fn_q[2] ? C_SHOW : C_RES)) begin
            state_d = DONE;
            out_d = fn_q[2] ? {a_q, b_q} : res_q;
            err_d = fault_q;
            seg_d = seg_c;
         end else begin
            cnt_d = cnt_q + 1'b1;
            if (fn_q[2] && cnt_q == C_OPS) begin
               bcd_a_d = bcd_q[7:0];
               bcd_d = '0;
            end else begin
               bcd_d = BW'({dab, mag_q[RW-1]});
               mag_d = mag_q << 1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         cnt_q <= '0;
         fn_q <= '0;
         a_q <= '0;
         b_q <= '0;
         ma_q <= '0;
         mb_q <= '0;
         acc_q <= '0;
         res_q <= '0;
         mag_q <= '0;
         bcd_q <= '0;
         bcd_a_q <= '0;
         fault_q <= 1'b0;
         out_q <= '0;
         err_q <= 1'b0;
         seg_q <= '1;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         fn_q <= fn_d;
         a_q <= a_d;
         b_q <= b_d;
         ma_q <= ma_d;
         mb_q <= mb_d;
         acc_q <= acc_d;
         res_q <= res_d;
         mag_q <= mag_d;
         bcd_q <= bcd_d;
         bcd_a_q <= bcd_a_d;
         fault_q <= fault_d;
         out_q <= out_d;
         err_q <= err_d;
         seg_q <= seg_d;
      end

   assign busy = state_q != IDLE;
   assign done = state_q == DONE;
   assign out = out_q;
   assign err = err_q;
   for (genvar j = 0; j < 7*N_SEGS; j++) begin : g_segs
      assign segs[j] = seg_q[j];
   end
endmodule

// File: tb/tb_seq_alu_display.sv
// tb_seq_alu_display: directed and randomized checks of seq_alu_display against an integer reference model.
module tb_seq_alu_display;
   localparam int W = 6;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic [2:0] func = '0;
   logic busy, done, err;
   logic [2*W-1:0] out;
   logic [0:55] segs;
   int checks = 0, errors = 0, nd;
   bit lz;
   logic [6:0] seg_hi [10] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07, 7'h7f, 7'h6f};
   int pow10 [4] = '{1, 10, 100, 1000};

   seq_alu_display #(.WIDTH(W), .DIGITS(4), .N_SEGS(8)) dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .func(func), .start(start),
      .busy(busy), .done(done), .out(out), .segs(segs), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // -1 blank, -2 minus sign, else decimal digit; returns active-low pattern
   function automatic logic [6:0] glyph(input int d);
      return d == -1 ? 7'h7f : d == -2 ? 7'h3f : ~seg_hi[d];
   endfunction

   task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [2:0] fv);
      int sa, sb, r, v, lat, elat, badb;
      int dig [8];
      bit e;
      logic [11:0] eo;
      logic [0:55] es;
      logic [6:0] g;
      sa = int'($signed(av));
      sb = int'($signed(bv));
      e = 1'b0;
      r = 0;
      case (fv[1:0])
         2'b00: r = sa + sb;
         2'b01: r = sa - sb;
         2'b10: r = sa * sb;
         default: if (sb == 0) e = 1'b1; else r = sa / sb;
      endcase
      for (int i = 0; i < 8; i++) dig[i] = -1;
      if (fv[2]) begin
         v = sb < 0 ? -sb : sb;
         dig[0] = v % 10;
         dig[1] = (lz && v < 10) ? -1 : v / 10;
         dig[2] = sb < 0 ? -2 : -1;
         v = sa < 0 ? -sa : sa;
         dig[4] = v % 10;
         dig[5] = (lz && v < 10) ? -1 : v / 10;
         dig[6] = sa < 0 ? -2 : -1;
         eo = {av, bv};
         e = 1'b0;
      end else if (e) begin
         for (int i = 0; i < 5; i++) dig[i] = -2;
         eo = '0;
      end else begin
         v = r < 0 ? -r : r;
         for (int i = 0; i < 4; i++) dig[i] = (lz && i > 0 && v < pow10[i]) ? -1 : (v / pow10[i]) % 10;
         dig[4] = r < 0 ? -2 : -1;
         eo = r[11:0];
      end
      for (int i = 0; i < 8; i++) begin
         g = glyph(dig[i]);
         for (int k = 0; k < 7; k++) es[7*i+k] = g[k];
      end
      elat = (!fv[2] && fv[1] && !e) ? 3*W+2 : 2*W+2;
      @(negedge clk);
      a = av;
      b = bv;
      func = fv;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      func = 3'($urandom);
      lat = 0;
      badb = 0;
      while (!done && lat < 60) begin
         @(posedge clk);
         #1;
         lat++;
         if (!busy) badb++;
         start = done ? 1'b0 : 1'($urandom);
      end
      start = 1'b0;
      chk("latency", lat, elat);
      chk("busy_during", badb, 0);
      chk("out", out, eo);
      chk("err", err, e);
      chk("segs", segs, es);
      @(posedge clk);
      #1;
      chk("done_pulse", done, 0);
      chk("idle_after", busy, 0);
   endtask

   initial begin
      lz = 1'b0;
`ifdef SEQ_ALU_LZ_BLANK_EN
      lz = 1'b1;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_out", out, 0);
      chk("rst_err", err, 0);
      chk("rst_segs", segs, {56{1'b1}});
      @(negedge clk) rst = 1'b0;
      run_op(6'd5, 6'b111101, 3'b000);
      run_op(6'b100000, 6'b100000, 3'b010);
      run_op(6'b100001, 6'd4, 3'b011);
      run_op(6'd9, 6'd0, 3'b011);
      run_op(6'b111001, 6'd21, 3'b100);
      run_op(6'd0, 6'd0, 3'b000);
      run_op(6'b100000, 6'b111111, 3'b011);
      run_op(6'd31, 6'd31, 3'b010);
      run_op(6'b100000, 6'd1, 3'b001);
      run_op(6'd31, 6'b100000, 3'b001);
      run_op(6'd0, 6'd5, 3'b111);
      run_op(6'b100000, 6'b100000, 3'b110);
      run_op(6'd31, 6'b100000, 3'b010);
      for (int n = 0; n < 40; n++) run_op(W'($urandom), W'($urandom), 3'($urandom));
      run_op(6'd3, 6'd7, 3'b010);
      @(negedge clk);
      a = 6'b100000;
      b = 6'd7;
      func = 3'b010;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_out", out, 0);
      chk("abort_err", err, 0);
      chk("abort_segs", segs, {56{1'b1}});
      @(negedge clk) rst = 1'b0;
      run_op(6'd2, 6'd3, 3'b010);
      @(negedge clk);
      a = 6'd3;
      b = 6'd4;
      func = 3'b010;
      start = 1'b1;
      nd = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done) begin
            nd++;
            start = 1'b0;
         end
      end
      start = 1'b0;
      chk("held_dones", nd, 1);
      chk("held_out", out, 12);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
